// File: rtl/equalize_pkg.sv
// Shared types and constants for the histogram-equalisation output stage.
// Holds the FSM state enum, default widths and the level helper.
package equalize_pkg;

  localparam int CDF_W_DEF = 20;
  localparam int PIX_W_DEF = 8;
  localparam int TAG_W_DEF = 18;

  localparam int LEVELS = 1 << PIX_W_DEF;
  localparam int NUM_W  = CDF_W_DEF + PIX_W_DEF + 1;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_t;

  function automatic int levels_max(input int pix_w);
    return (1 << pix_w) - 1;
  endfunction

endpackage

// File: rtl/equalize_divider.sv
// Restoring divider, one quotient bit per cycle, MSB first.
// Ports: start loads num/den, busy while iterating, done pulses with quo.
module equalize_divider
  import equalize_pkg::*;
#(
  parameter int CDF_W = CDF_W_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CDF_W+PIX_W:0]     num,
  input  logic [CDF_W-1:0]         den,
  output logic                     busy,
  output logic                     done,
  output logic [PIX_W-1:0]         quo
);

  localparam int CNT_W = $clog2(PIX_W + 1);

  logic [CDF_W:0]   rem;
  logic [PIX_W-1:0] low;
  logic [CDF_W-1:0] den_q;
  logic [CNT_W-1:0] cnt;
  logic [CDF_W+1:0] trial;
  logic [CDF_W+1:0] diff;
  logic             ge;

  // low holds the untouched numerator bits; quotient bits
  // shift in from the bottom as those bits are consumed.
  assign trial = {rem, low[PIX_W-1]};
  assign diff  = trial - {2'b00, den_q};
  assign ge    = trial >= {2'b00, den_q};
  assign quo   = low;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem   <= '0;
      low   <= '0;
      den_q <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem   <= num[CDF_W+PIX_W:PIX_W];
        low   <= num[PIX_W-1:0];
        den_q <= den;
        cnt   <= CNT_W'(PIX_W - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        rem <= ge ? diff[CDF_W:0] : trial[CDF_W:0];
        low <= {low[PIX_W-2:0], ge};
        if (cnt == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/output_equalize_pipe.sv
// Equalised grey level from a pixel CDF, with rounding, clamping and tag.
// Ports: in_* valid/ready beat (cdf, cdf_min, total, tag); out_* result.
module output_equalize_pipe
  import equalize_pkg::*;
#(
  parameter int CDF_W = CDF_W_DEF,
  parameter int PIX_W = PIX_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CDF_W-1:0] in_cdf,
  input  logic [CDF_W-1:0] in_cdf_min,
  input  logic [CDF_W-1:0] in_total,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NW = CDF_W + PIX_W + 1;
  localparam logic [PIX_W-1:0] PMAX = PIX_W'(levels_max(PIX_W));

  state_t           state;
  logic             under_q;
  logic             zden_q;
  logic             over_q;
  logic [TAG_W-1:0] tag_q;
  logic             accept;
  logic             under;
  logic             zden;
  logic             over;
  logic [CDF_W-1:0] d;
  logic [CDF_W-1:0] den;
  logic [NW-1:0]    num;
  logic             div_busy;
  logic             div_done;
  logic [PIX_W-1:0] quo;
  logic [PIX_W-1:0] pix_sel;

  assign accept = (state == IDLE) && in_valid && in_ready;
  assign under  = in_cdf < in_cdf_min;
  assign zden   = in_total == in_cdf_min;
  assign over   = in_cdf > in_total;
  assign d      = under ? '0 : in_cdf - in_cdf_min;
  assign den    = in_total - in_cdf_min;

  // d * (LEVELS-1) as a shift-subtract, plus den/2 so the
  // truncating divide rounds to nearest.
  assign num = {1'b0, d, {PIX_W{1'b0}}} - NW'(d) + NW'(den >> 1);

  equalize_divider #(
    .CDF_W (CDF_W),
    .PIX_W (PIX_W)
  ) u_div (
    .clock (clock),
    .reset (reset),
    .start (accept),
    .num   (num),
    .den   (den),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (quo)
  );

  always_comb begin
    pix_sel = quo;
    priority case (1'b1)
      zden_q || under_q: pix_sel = '0;
      over_q:            pix_sel = PMAX;
      default:           pix_sel = quo;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_tag   <= '0;
      tag_q     <= '0;
      under_q   <= 1'b0;
      zden_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            tag_q    <= in_tag;
            under_q  <= under;
            zden_q   <= zden;
            over_q   <= over;
            in_ready <= 1'b0;
            state    <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (div_done && !div_busy) begin
            out_valid <= 1'b1;
            out_pixel <= pix_sel;
            out_tag   <= tag_q;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
